ports_rx: RTL and testbench

PORTS_RX -- requirements
Module: ports_rx

---
 rtl/ports_pkg.sv | 20 ++
 rtl/ports_rx_shift.sv | 55 +++++
 rtl/ports_rx.sv | 129 ++++++++++++
 tb/tb_ports_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ports_pkg.sv
// rtl/ports_pkg.sv - shared state encoding and defaults for the ports_rx receiver
package ports_pkg;

  // Default number of data bits per frame
  localparam int DATA_W_DEF = 8;

  // Receiver state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } rx_state_e;

endpackage

// File: rtl/ports_rx_shift.sv
// rtl/ports_rx_shift.sv - receive shift register with running parity (PORTS_RX_PARITY_EN adds the parity output)
module ports_rx_shift
  import ports_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [CNT_W-1:0]  pos_i,
  input  logic              bit_i,
`ifdef PORTS_RX_PARITY_EN
  output logic              par_o,
`endif
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q, data_d;

  // Place the incoming bit at its frame position; cleared at each start bit
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (wr_i) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (pos_i == CNT_W'(i)) data_d[i] = bit_i;
      end
    end
  end

  // Shift register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data_o = data_q;

`ifdef PORTS_RX_PARITY_EN
  logic par_q;

  // Running XOR of the data bits written so far in this frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     par_q <= 1'b0;
    else if (clr_i) par_q <= 1'b0;
    else if (wr_i)  par_q <= par_q ^ bit_i;
  end

  assign par_o = par_q;
`endif

endmodule

// File: rtl/ports_rx.sv
// rtl/ports_rx.sv - strobed serial frame receiver (PORTS_RX_PARITY_EN enables the even-parity bit)
module ports_rx
  import ports_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              sd,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int               CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              frame_err_q;
  logic [DATA_W-1:0] shift_data;
  logic              shift_clr;
  logic              shift_wr;

  assign shift_clr = bit_en && (state_q == IDLE) && !sd;
  assign shift_wr  = bit_en && (state_q == DATA);

`ifdef PORTS_RX_PARITY_EN
  logic shift_par;
  logic mis_q;
  logic parity_err_q;
`endif

  ports_rx_shift #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (shift_clr),
    .wr_i   (shift_wr),
    .pos_i  (cnt_q),
    .bit_i  (sd),
`ifdef PORTS_RX_PARITY_EN
    .par_o  (shift_par),
`endif
    .data_o (shift_data)
  );

  // Frame FSM; advances only on strobe cycles, result pulses last one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PORTS_RX_PARITY_EN
      mis_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rvalid_q     <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PORTS_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (!sd) begin
              state_q <= DATA;
              cnt_q   <= '0;
            end
          end
          DATA: begin
            // Counter parks at the last index instead of wrapping
            if (cnt_q == LAST) begin
`ifdef PORTS_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PARITY: begin
`ifdef PORTS_RX_PARITY_EN
            mis_q   <= sd ^ shift_par;
            state_q <= STOP;
`else
            state_q <= IDLE;
`endif
          end
          STOP: begin
            if (sd) begin
              rdata_q      <= shift_data;
              rvalid_q     <= 1'b1;
`ifdef PORTS_RX_PARITY_EN
              parity_err_q <= mis_q;
`endif
            end else begin
              frame_err_q  <= 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
`ifdef PORTS_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ports_rx.sv
// tb/tb_ports_rx.sv - scoreboard bench for ports_rx with randomized frames
module tb_ports_rx;

`ifdef PORTS_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       bit_en;
  logic       sd;
  logic [7:0] rdata;
  logic       rvalid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  ports_rx #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .sd         (sd),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  typedef struct {
    logic       v;
    logic       fe;
    logic       pe;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] last_good = 8'h00;
  bit         chk_busy  = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: every pulse cycle must match the oldest expected outcome
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (rvalid || frame_err || parity_err)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {29'd0, rvalid, frame_err, parity_err}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("rvalid",     rvalid,     e.v);
          check("frame_err",  frame_err,  e.fe);
          check("parity_err", parity_err, e.pe);
          check("rdata",      rdata,      e.d);
          check("latency",    cyc,        e.cyc);
        end
      end
    end
  end

  // One bit cell: per-1 non-strobe cycles with junk on the line, then the strobe
  task automatic strobe_bit(input logic b, input int per);
    for (int i = 0; i < per - 1; i++) begin
      @(posedge clk); #1;
      bit_en = 1'b0;
      sd     = 1'($urandom_range(0, 1));
      if (chk_busy) begin
        @(negedge clk);
        check("busy_hold", busy, 1'b1);
      end
    end
    @(posedge clk); #1;
    bit_en = 1'b1;
    sd     = b;
  endtask

  task automatic idle_bits(input int n, input int per);
    for (int i = 0; i < n; i++) strobe_bit(1'b1, per);
  endtask

  // Send one frame and record the outcome the receiver must report
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip, input int per);
    exp_t e;
    logic ok_par;
    ok_par = 1'($countones(d) % 2);
    strobe_bit(1'b0, per);
    chk_busy = 1'b1;
    for (int i = 0; i < 8; i++) strobe_bit(d[i], per);
    if (PAR) strobe_bit(ok_par ^ par_flip, per);
    strobe_bit(stop_b, per);
    chk_busy = 1'b0;
    e.cyc = cyc + 1;
    if (stop_b) begin
      e.v = 1'b1; e.fe = 1'b0; e.pe = PAR & par_flip; e.d = d;
      last_good = d;
    end else begin
      e.v = 1'b0; e.fe = 1'b1; e.pe = 1'b0; e.d = last_good;
    end
    sb_q.push_back(e);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    bit_en = 1'b0;
    sd     = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    bit_en = 1'b0;
    sd     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdata",      rdata,      8'h00);
    check("rst_rvalid",     rvalid,     1'b0);
    check("rst_frame_err",  frame_err,  1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_busy",       busy,       1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic frame, then same frame with a bad stop bit
    send_frame(8'h4A, 1'b1, 1'b0, 1);
    idle_bits(1, 1);
    send_frame(8'h4A, 1'b0, 1'b0, 1);
    idle_bits(2, 1);

    // All-ones data with correct and wrong parity bit
    send_frame(8'hFF, 1'b1, 1'b1, 1);
    idle_bits(1, 1);
    send_frame(8'hFF, 1'b1, 1'b0, 1);
    idle_bits(1, 1);

    // Slow strobe: one bit every 4th cycle
    send_frame(8'h81, 1'b1, 1'b0, 4);
    go_idle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // Reset in the middle of a frame, then a clean frame
    strobe_bit(1'b0, 1);
    strobe_bit(1'b0, 1);
    strobe_bit(1'b0, 1);
    strobe_bit(1'b1, 1);
    @(posedge clk); #1;
    bit_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",  busy,  1'b0);
    check("midrst_rdata", rdata, 8'h00);
    last_good = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0, 1);

    // Back-to-back frames with no idle bit in between
    send_frame(8'h12, 1'b1, 1'b0, 1);
    send_frame(8'h34, 1'b1, 1'b0, 1);
    idle_bits(1, 1);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      int per;
      per = int'($urandom_range(1, 4));
      send_frame(8'($urandom), ($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)), per);
      idle_bits(int'($urandom_range(0, 2)), per);
    end
    go_idle();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
